mem_stream_agu: RTL
===================

# mem_stream_agu

Streaming address generator and access initiator for the single-port `Mem` primitive; it is the requesting end of `Mem`'s `addr0`/`write_data`/`write_en`/`read_data` port. On a start command it issues a strided sequence of word reads (load mode) or writes (store mode). Load data is delivered to the fabric over a valid/ready stream; store data is taken from the fabric the same way. It sits between a `Mem` instance and the compute fabric (`ALU`/`reg_unit` datapaths).

## Interface
- `READ_LATENCY`, 1: cycles from `mem_addr` presented to `mem_read_data` valid; legal range 1..4.
- `FIFO_DEPTH`, 2: load return buffer entries; must be ≥ `READ_LATENCY`+1.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command pulse; sampled only in IDLE.
- `mode` in 1: 0 = load, 1 = store; sampled with `start`.
- `base` in 32: first word address; sampled with `start`.
- `stride` in 32: two's-complement address increment; sampled with `start`.
- `count` in 16: number of words; sampled with `start`.
- `busy` out 1: high in LOAD, DRAIN and STORE.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out 32: to `Mem.addr0`.
- `mem_write_data` out 32: to `Mem.write_data`.
- `mem_write_en` out 1: to `Mem.write_en`.
- `mem_read_data` in 32: from `Mem.read_data`.
- `ld_data` out 32, `ld_valid` out 1, `ld_ready` in 1: load stream to the fabric.
- `st_data` in 32, `st_valid` in 1, `st_ready` out 1: store stream from the fabric.

## Operation
- States: IDLE, LOAD, DRAIN, STORE, DONE.
- IDLE + `start`:
  - `count`=0 → DONE.
  - `mode`=0 → LOAD.
  - `mode`=1 → STORE.
- `start` in any state other than IDLE is ignored.
- Address arithmetic is modulo 2^32. The k-th word (k = 0..count-1) uses address `base`+k·`stride`. A negative stride walks downward; wrap past 0 or 0xFFFFFFFF is silent.
- LOAD issue:
  - A read is issued in a cycle when `issued` < `count` and occ + inflight − pop < `FIFO_DEPTH`. Here occ is the FIFO occupancy, inflight is the number of reads issued but not yet returned, and pop = `ld_valid`&&`ld_ready`.
  - On issue, `mem_addr` holds the k-th address that cycle and advances by `stride` for the next cycle.
  - `mem_write_en` stays 0 throughout LOAD and DRAIN.
- Load return: `mem_read_data` is captured into the FIFO exactly `READ_LATENCY` cycles after its issue cycle. Word order is preserved.
- Load stream: `ld_valid` = FIFO non-empty and `ld_data` = FIFO head, both registered. A word is popped when `ld_valid`&&`ld_ready`.
- LOAD → DRAIN once `count` reads are issued. DRAIN → DONE in the cycle the last word is popped.
- STORE:
  - `st_ready` = 1 while accepted < `count`.
  - Accept occurs on `st_valid`&&`st_ready`.
  - For the k-th accept at cycle t: at t+1, `mem_write_en`=1, `mem_addr`=`base`+k·`stride` and `mem_write_data`=accepted word.
  - `mem_write_en`=0 in every cycle without a pending write.
- STORE → DONE after the cycle in which the last write is driven.
- DONE lasts one cycle: `done`=1, `busy`=0. Then → IDLE.
- `reset` (including mid-operation):
  - State → IDLE; FIFO flushed; in-flight returns discarded; counters cleared.
  - No `done` pulse is produced for the aborted operation.
  - A write already registered for the reset cycle is suppressed.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_addr`=0, `mem_write_data`=0, `mem_write_en`=0, `ld_valid`=0, `ld_data`=0, `st_ready`=0.
- All outputs are registered. No combinational path exists from any input to any output.
- Load, `start` in cycle 0:
  - `mem_addr`=`base` in cycle 1.
  - Data captured at end of cycle 1+`READ_LATENCY`.
  - First `ld_valid` in cycle 2+`READ_LATENCY`.
- Load throughput: 1 word/cycle with `ld_ready` held high and `FIFO_DEPTH` ≥ `READ_LATENCY`+1.
- Load backpressure:
  - With `ld_ready` low, issue stalls when occ + inflight reaches `FIFO_DEPTH`. No returned word is ever dropped.
  - `ld_data` is stable while `ld_valid`&&!`ld_ready`.
- Store, `start` in cycle 0: `st_ready` high from cycle 1. Throughput 1 word/cycle.
- Completion:
  - `count`=0: `done` in cycle 1.
  - Load: `done` one cycle after the last pop.
  - Store: `done` one cycle after the last `mem_write_en` cycle.
- Simultaneous pop and capture in the same cycle leaves occ unchanged. This is legal when the FIFO is full.

## Test plan
- Load, `base`=0x100, `stride`=4, `count`=4, `READ_LATENCY`=1, `ld_ready`=1, memory model word(a)=a → `ld_data` 0x100, 0x104, 0x108, 0x10C on cycles 3–6; `done` in cycle 7.
- Same load with `ld_ready` toggled 1,0,0,1,…:
  - In-flight count never exceeds `FIFO_DEPTH`.
  - All 4 words delivered in order with no loss or duplication.
  - `ld_data` held steady while stalled.
- Store, `base`=0xFFFFFFFC, `stride`=4, `count`=3, `st_data` 0xA,0xB,0xC with gaps in `st_valid` → writes to 0xFFFFFFFC, 0x0, 0x4, each one cycle after its accept; `st_ready` drops after the third accept.
- `count`=0 load and store → `done` in cycle 1, no `mem_write_en`, no `ld_valid`. A second `start` while `busy` → ignored, addresses unchanged.
- `stride`=0xFFFFFFF8 (−8), `base`=0x20, `count`=3 load → addresses 0x20, 0x18, 0x10.
- Assert `reset` during DRAIN with 2 words buffered → next cycle all outputs at reset values, no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/mem_stream_agu.sv
// mem_stream_agu: streaming address generator and access initiator for a single-port Mem.
// On a start command it walks base + k*stride (k = 0..count-1) and either issues word reads
// (load mode, data returned to the fabric over ld_*) or word writes (store mode, data taken
// from the fabric over st_*). All outputs are registered.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, mode, base, stride,    command; sampled only in IDLE
//   count
//   busy, done                    status; done is a one-cycle completion pulse
//   mem_addr, mem_write_data,     request side of Mem (addr0 / write_data / write_en)
//   mem_write_en, mem_read_data
//   ld_data, ld_valid, ld_ready   load stream to the fabric
//   st_data, st_valid, st_ready   store stream from the fabric
module mem_stream_agu #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base,
    input  logic [31:0] stride,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    input  logic [31:0] mem_read_data,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    input  logic        ld_ready,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    output logic        st_ready
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StStore, StDone} state_t;

    state_t                  state_q;
    logic [31:0]             stride_q;
    logic [15:0]             count_q;
    logic [31:0]             addr_q;     // next store address
    logic [15:0]             k_q;        // reads issued (load) / words accepted (store)
    logic [15:0]             popped_q;   // load words delivered to the fabric
    logic [READ_LATENCY-1:0] pipe_q;     // one bit per read in flight, oldest at the top
    logic [31:0]             fifo_q [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [OW-1:0]           occ_q;

    logic                    pop;
    logic                    cap;
    logic                    issue;
    logic                    accept;
    int                      inflight;
    logic [OW-1:0]           occ_after_pop;
    logic [OW-1:0]           occ_n;
    logic [PW-1:0]           rd_ptr_n;
    logic [31:0]             head_n;
    logic [READ_LATENCY-1:0] pipe_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop      = ld_valid && ld_ready;
        cap      = pipe_q[READ_LATENCY-1];
        accept   = st_valid && st_ready;
        inflight = $countones(pipe_q);
        // mem_addr already presents the candidate address; a read counts as issued only if
        // its return is guaranteed a FIFO slot once everything older has landed.
        issue    = (state_q == StLoad) && (k_q < count_q) &&
                   ((int'(occ_q) + inflight - int'(pop)) < int'(FIFO_DEPTH));
        occ_after_pop = occ_q - OW'(pop);
        occ_n         = occ_after_pop + OW'(cap);
        rd_ptr_n      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        // An empty FIFO makes the word being captured now the next head.
        head_n        = (occ_after_pop == '0) ? mem_read_data : fifo_q[rd_ptr_n];
        pipe_d        = '0;
        pipe_d[0]     = issue;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            stride_q       <= '0;
            count_q        <= '0;
            addr_q         <= '0;
            k_q            <= '0;
            popped_q       <= '0;
            pipe_q         <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            occ_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_en   <= 1'b0;
            ld_data        <= '0;
            ld_valid       <= 1'b0;
            st_ready       <= 1'b0;
        end else begin
            // Load return path; idle outside LOAD/DRAIN because nothing is in flight.
            pipe_q   <= pipe_d;
            occ_q    <= occ_n;
            rd_ptr_q <= rd_ptr_n;
            if (cap) begin
                fifo_q[wr_ptr_q] <= mem_read_data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            ld_valid <= (occ_n != '0);
            if (occ_n != '0) begin
                ld_data <= head_n;
            end
            if (pop) begin
                popped_q <= popped_q + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    done         <= 1'b0;
                    mem_write_en <= 1'b0;
                    if (start) begin
                        stride_q <= stride;
                        count_q  <= count;
                        k_q      <= '0;
                        popped_q <= '0;
                        if (count == 16'd0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (!mode) begin
                            state_q  <= StLoad;
                            busy     <= 1'b1;
                            mem_addr <= base;
                        end else begin
                            state_q  <= StStore;
                            busy     <= 1'b1;
                            st_ready <= 1'b1;
                            addr_q   <= base;
                        end
                    end
                end
                StLoad: begin
                    if (issue) begin
                        mem_addr <= mem_addr + stride_q;
                        k_q      <= k_q + 16'd1;
                        if (k_q + 16'd1 == count_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && (popped_q == count_q - 16'd1)) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StStore: begin
                    if (accept) begin
                        mem_write_en   <= 1'b1;
                        mem_addr       <= addr_q;
                        mem_write_data <= st_data;
                        addr_q         <= addr_q + stride_q;
                        k_q            <= k_q + 16'd1;
                        st_ready       <= (k_q + 16'd1 != count_q);
                    end else begin
                        mem_write_en <= 1'b0;
                    end
                    // The final write is on the bus this cycle; no further accept is possible.
                    if (mem_write_en && (k_q == count_q)) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
